// File: rtl/tx_desc_fetch.sv
// Transmit descriptor fetch engine: walks the host TX ring from the fetch pointer
// towards TDT and issues one three-beat iDMA read command per contiguous chunk.
module tx_desc_fetch #(
    parameter int BURST_MAX = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        EN,
    input  logic [63:0] TDBA,
    input  logic [12:0] TDLEN,
    input  logic [15:0] TDH,
    input  logic [15:0] TDT,
    input  logic [7:0]  space_avail,
    output logic [31:0] cmd_tdata,
    output logic        cmd_tvalid,
    output logic        cmd_tlast,
    input  logic        cmd_tready,
    input  logic [31:0] cpl_tdata,
    input  logic        cpl_tvalid,
    input  logic        cpl_tlast,
    output logic        cpl_tready,
    output logic [15:0] fetch_ptr,
    output logic        fetch_done,
    output logic [7:0]  fetch_cnt,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, CALC, CMD0, CMD1, CMD2, WAIT_CPL, UPDATE, HALT
    } state_t;

    localparam logic [16:0] BURST_LIM = 17'(BURST_MAX);

    state_t      state_reg;
    logic [15:0] fptr_reg;
    logic [15:0] next_ptr_reg;
    logic [7:0]  count_reg;
    logic [63:0] addr_reg;
    logic [31:0] cmd_tdata_reg;
    logic        cmd_tvalid_reg;
    logic        cmd_tlast_reg;
    logic        cpl_tready_reg;
    logic        fetch_done_reg;
    logic [7:0]  fetch_cnt_reg;
    logic        err_reg;

    logic [16:0] ring_n;
    logic [16:0] fptr_ext;
    logic [16:0] tdt_ext;
    logic        cfg_valid;
    logic [16:0] pending;
    logic [16:0] to_wrap;
    logic [16:0] min_cnt;
    logic [7:0]  count_next;
    logic [63:0] addr_next;
    logic [16:0] fptr_adv;
    logic [15:0] next_ptr_next;

    logic unused_cpl;
    assign unused_cpl = &{1'b0, cpl_tdata[31:2], cpl_tlast};

    assign ring_n   = {1'b0, TDLEN, 3'b000};
    assign fptr_ext = {1'b0, fptr_reg};
    assign tdt_ext  = {1'b0, TDT};
    // A stale TDH beyond the ring end is treated like a bad config rather than underflowing.
    assign cfg_valid = (ring_n != 17'd0) && (tdt_ext < ring_n) && (fptr_ext < ring_n);
    assign pending   = (tdt_ext >= fptr_ext) ? (tdt_ext - fptr_ext)
                                             : (tdt_ext + ring_n - fptr_ext);
    assign to_wrap   = ring_n - fptr_ext;

    always_comb begin
        min_cnt = pending;
        if (to_wrap < min_cnt)
            min_cnt = to_wrap;
        if (BURST_LIM < min_cnt)
            min_cnt = BURST_LIM;
        if ({9'd0, space_avail} < min_cnt)
            min_cnt = {9'd0, space_avail};
    end

    assign count_next    = min_cnt[7:0];
    assign addr_next     = TDBA + {44'd0, fptr_reg, 4'b0000};
    assign fptr_adv      = fptr_ext + {9'd0, count_next};
    assign next_ptr_next = (fptr_adv == ring_n) ? 16'd0 : fptr_adv[15:0];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg      <= IDLE;
            fptr_reg       <= 16'd0;
            next_ptr_reg   <= 16'd0;
            count_reg      <= 8'd0;
            addr_reg       <= 64'd0;
            cmd_tdata_reg  <= 32'd0;
            cmd_tvalid_reg <= 1'b0;
            cmd_tlast_reg  <= 1'b0;
            cpl_tready_reg <= 1'b0;
            fetch_done_reg <= 1'b0;
            fetch_cnt_reg  <= 8'd0;
            err_reg        <= 1'b0;
        end else begin
            fetch_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    fptr_reg <= TDH;
                    if (EN)
                        state_reg <= CALC;
                end
                CALC: begin
                    if (!EN) begin
                        state_reg <= IDLE;
                    end else if (cfg_valid && count_next != 8'd0) begin
                        // Length, address and next pointer are frozen here for the whole command.
                        count_reg      <= count_next;
                        addr_reg       <= addr_next;
                        next_ptr_reg   <= next_ptr_next;
                        cmd_tdata_reg  <= {4'h1, 12'h000, 4'h0, count_next, 4'h0};
                        cmd_tvalid_reg <= 1'b1;
                        state_reg      <= CMD0;
                    end
                end
                CMD0: begin
                    if (cmd_tready) begin
                        cmd_tdata_reg <= addr_reg[31:0];
                        state_reg     <= CMD1;
                    end
                end
                CMD1: begin
                    if (cmd_tready) begin
                        cmd_tdata_reg <= addr_reg[63:32];
                        cmd_tlast_reg <= 1'b1;
                        state_reg     <= CMD2;
                    end
                end
                CMD2: begin
                    if (cmd_tready) begin
                        cmd_tdata_reg  <= 32'd0;
                        cmd_tvalid_reg <= 1'b0;
                        cmd_tlast_reg  <= 1'b0;
                        cpl_tready_reg <= 1'b1;
                        state_reg      <= WAIT_CPL;
                    end
                end
                WAIT_CPL: begin
                    if (cpl_tvalid) begin
                        cpl_tready_reg <= 1'b0;
                        if (cpl_tdata[1:0] == 2'b00) begin
                            fptr_reg       <= next_ptr_reg;
                            fetch_done_reg <= 1'b1;
                            fetch_cnt_reg  <= count_reg;
                            state_reg      <= UPDATE;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= HALT;
                        end
                    end
                end
                UPDATE: begin
                    state_reg <= CALC;
                end
                HALT: begin
                    if (!EN)
                        state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_tdata  = cmd_tdata_reg;
    assign cmd_tvalid = cmd_tvalid_reg;
    assign cmd_tlast  = cmd_tlast_reg;
    assign cpl_tready = cpl_tready_reg;
    assign fetch_ptr  = fptr_reg;
    assign fetch_done = fetch_done_reg;
    assign fetch_cnt  = fetch_cnt_reg;
    assign err        = err_reg;
    assign busy       = (state_reg == CMD0) || (state_reg == CMD1) || (state_reg == CMD2) ||
                        (state_reg == WAIT_CPL) || (state_reg == UPDATE);

endmodule

// File: tb/tb_tx_desc_fetch.sv
// Directed bench for tx_desc_fetch: ring walks, wrap, burst/space limits,
// back-pressure, error completion, enable drop, bad config and mid-command reset.
module tb_tx_desc_fetch;

    logic        aclk = 1'b0;
    logic        areset;
    logic        EN;
    logic [63:0] TDBA;
    logic [12:0] TDLEN;
    logic [15:0] TDH;
    logic [15:0] TDT;
    logic [7:0]  space_avail;
    logic [31:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tlast;
    logic        cmd_tready;
    logic [31:0] cpl_tdata;
    logic        cpl_tvalid;
    logic        cpl_tlast;
    logic        cpl_tready;
    logic [15:0] fetch_ptr;
    logic        fetch_done;
    logic [7:0]  fetch_cnt;
    logic        busy;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    tx_desc_fetch #(.BURST_MAX(16)) dut (
        .aclk(aclk), .areset(areset), .EN(EN), .TDBA(TDBA), .TDLEN(TDLEN),
        .TDH(TDH), .TDT(TDT), .space_avail(space_avail),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tlast(cmd_tlast),
        .cmd_tready(cmd_tready), .cpl_tdata(cpl_tdata), .cpl_tvalid(cpl_tvalid),
        .cpl_tlast(cpl_tlast), .cpl_tready(cpl_tready), .fetch_ptr(fetch_ptr),
        .fetch_done(fetch_done), .fetch_cnt(fetch_cnt), .busy(busy), .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a beat, checks it, and lets it handshake on the next edge.
    task automatic expect_beat(input string tag, input logic [31:0] data, input logic last);
        int w;
        w = 0;
        while (!cmd_tvalid && w < 20) begin
            tick();
            w++;
        end
        chk({tag, " valid"}, {63'd0, cmd_tvalid}, 64'd1);
        chk({tag, " data"}, {32'd0, cmd_tdata}, {32'd0, data});
        chk({tag, " last"}, {63'd0, cmd_tlast}, {63'd0, last});
        $display("beat %s: data=0x%08h last=%0b", tag, cmd_tdata, cmd_tlast);
        tick();
    endtask

    task automatic complete(input string tag, input logic [1:0] resp);
        int w;
        w = 0;
        while (!cpl_tready && w < 20) begin
            tick();
            w++;
        end
        chk({tag, " cpl_tready"}, {63'd0, cpl_tready}, 64'd1);
        cpl_tvalid = 1'b1;
        cpl_tlast  = 1'b1;
        cpl_tdata  = {30'd0, resp};
        tick();
        cpl_tvalid = 1'b0;
        cpl_tlast  = 1'b0;
        cpl_tdata  = 32'd0;
        $display("completion %s: resp=%0d", tag, resp);
    endtask

    task automatic chk_done(input string tag, input logic [7:0] cnt, input logic [15:0] ptr);
        chk({tag, " fetch_done"}, {63'd0, fetch_done}, 64'd1);
        chk({tag, " fetch_cnt"}, {56'd0, fetch_cnt}, {56'd0, cnt});
        chk({tag, " fetch_ptr"}, {48'd0, fetch_ptr}, {48'd0, ptr});
        $display("fetch %s: cnt=%0d ptr=%0d", tag, fetch_cnt, fetch_ptr);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (cmd_tvalid)
                n++;
        end
    endtask

    initial begin
        int nv;
        areset = 1'b1; EN = 1'b0; TDBA = 64'h1_0000_0000; TDLEN = 13'd2;
        TDH = 16'd0; TDT = 16'd0; space_avail = 8'd64; cmd_tready = 1'b1;
        cpl_tdata = 32'd0; cpl_tvalid = 1'b0; cpl_tlast = 1'b0;
        tick(); tick();
        chk("rst cmd_tvalid", {63'd0, cmd_tvalid}, 64'd0);
        chk("rst cmd_tdata", {32'd0, cmd_tdata}, 64'd0);
        chk("rst cpl_tready", {63'd0, cpl_tready}, 64'd0);
        chk("rst fetch_ptr", {48'd0, fetch_ptr}, 64'd0);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst err", {63'd0, err}, 64'd0);
        areset = 1'b0;
        tick();

        // Basic fetch of 5 descriptors, 2-cycle latency to first beat
        TDT = 16'd5; EN = 1'b1;
        tick();
        chk("lat cycle1 tvalid", {63'd0, cmd_tvalid}, 64'd0);
        tick();
        chk("lat cycle2 tvalid", {63'd0, cmd_tvalid}, 64'd1);
        chk("t1 busy", {63'd0, busy}, 64'd1);
        expect_beat("t1 b0", 32'h1000_0050, 1'b0);
        expect_beat("t1 b1", 32'h0000_0000, 1'b0);
        expect_beat("t1 b2", 32'h0000_0001, 1'b1);
        complete("t1", 2'd0);
        chk_done("t1", 8'd5, 16'd5);
        tick();
        chk("t1 done pulse", {63'd0, fetch_done}, 64'd0);
        count_valid(5, nv);
        chk("t1 no extra cmd", 64'(nv), 64'd0);

        // Wrap: fptr 12, TDT 3 on a 16-entry ring
        EN = 1'b0; TDH = 16'd12; TDT = 16'd3;
        tick(); tick();
        chk("t2 idle load", {48'd0, fetch_ptr}, 64'd12);
        EN = 1'b1;
        expect_beat("t2a b0", 32'h1000_0040, 1'b0);
        expect_beat("t2a b1", 32'h0000_00C0, 1'b0);
        expect_beat("t2a b2", 32'h0000_0001, 1'b1);
        complete("t2a", 2'd0);
        chk_done("t2a", 8'd4, 16'd0);
        expect_beat("t2b b0", 32'h1000_0030, 1'b0);
        expect_beat("t2b b1", 32'h0000_0000, 1'b0);
        expect_beat("t2b b2", 32'h0000_0001, 1'b1);
        complete("t2b", 2'd0);
        chk_done("t2b", 8'd3, 16'd3);

        // Space and burst limits on a 64-entry ring
        EN = 1'b0; TDLEN = 13'd8; TDH = 16'd0; TDT = 16'd40; space_avail = 8'd10;
        tick(); tick();
        EN = 1'b1;
        expect_beat("t3a b0", 32'h1000_00A0, 1'b0);
        expect_beat("t3a b1", 32'h0000_0000, 1'b0);
        expect_beat("t3a b2", 32'h0000_0001, 1'b1);
        complete("t3a", 2'd0);
        chk_done("t3a", 8'd10, 16'd10);
        space_avail = 8'd64;
        expect_beat("t3b b0", 32'h1000_0100, 1'b0);
        expect_beat("t3b b1", 32'h0000_00A0, 1'b0);
        expect_beat("t3b b2", 32'h0000_0001, 1'b1);
        complete("t3b", 2'd0);
        chk_done("t3b", 8'd16, 16'd26);
        expect_beat("t3c b0", 32'h1000_00E0, 1'b0);
        expect_beat("t3c b1", 32'h0000_01A0, 1'b0);
        expect_beat("t3c b2", 32'h0000_0001, 1'b1);
        complete("t3c", 2'd0);
        chk_done("t3c", 8'd14, 16'd40);

        // Back-pressure on the address beat, then an error completion
        TDT = 16'd45;
        expect_beat("t4 b0", 32'h1000_0050, 1'b0);
        cmd_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4 stall valid", {63'd0, cmd_tvalid}, 64'd1);
            chk("t4 stall data", {32'd0, cmd_tdata}, 64'h0000_0280);
        end
        cmd_tready = 1'b1;
        expect_beat("t4 b1", 32'h0000_0280, 1'b0);
        expect_beat("t4 b2", 32'h0000_0001, 1'b1);
        chk("t4 no dup beat", {63'd0, cmd_tvalid}, 64'd0);
        complete("t4", 2'd2);
        chk("t4 err pulse", {63'd0, err}, 64'd1);
        chk("t4 no done", {63'd0, fetch_done}, 64'd0);
        chk("t4 ptr held", {48'd0, fetch_ptr}, 64'd40);
        tick();
        chk("t4 err one cycle", {63'd0, err}, 64'd0);
        count_valid(8, nv);
        chk("t4 halt no cmd", 64'(nv), 64'd0);
        chk("t4 halt ptr frozen", {48'd0, fetch_ptr}, 64'd40);
        chk("t4 halt not busy", {63'd0, busy}, 64'd0);
        EN = 1'b0; TDH = 16'd20; TDT = 16'd22;
        tick(); tick();
        chk("t4 reload TDH", {48'd0, fetch_ptr}, 64'd20);

        // Enable drops while the completion is pending
        EN = 1'b1;
        expect_beat("t5 b0", 32'h1000_0020, 1'b0);
        expect_beat("t5 b1", 32'h0000_0140, 1'b0);
        expect_beat("t5 b2", 32'h0000_0001, 1'b1);
        EN = 1'b0;
        complete("t5", 2'd0);
        chk_done("t5", 8'd2, 16'd22);
        tick(); tick(); tick();
        chk("t5 back to idle ptr", {48'd0, fetch_ptr}, 64'd20);
        chk("t5 idle not busy", {63'd0, busy}, 64'd0);

        // Invalid configurations and zero free space never issue commands
        TDLEN = 13'd0; TDH = 16'd0; TDT = 16'd5; EN = 1'b1;
        count_valid(20, nv);
        chk("t6 TDLEN=0 no cmd", 64'(nv), 64'd0);
        TDLEN = 13'd2; TDT = 16'd16;
        count_valid(20, nv);
        chk("t6 TDT>=N no cmd", 64'(nv), 64'd0);
        TDT = 16'd5; space_avail = 8'd0;
        count_valid(10, nv);
        chk("t6 space=0 no cmd", 64'(nv), 64'd0);

        // Reset in the middle of a command
        space_avail = 8'd64;
        expect_beat("t7 b0", 32'h1000_0050, 1'b0);
        areset = 1'b1;
        tick();
        chk("t7 rst cmd_tvalid", {63'd0, cmd_tvalid}, 64'd0);
        chk("t7 rst cmd_tlast", {63'd0, cmd_tlast}, 64'd0);
        chk("t7 rst cmd_tdata", {32'd0, cmd_tdata}, 64'd0);
        chk("t7 rst fetch_cnt", {56'd0, fetch_cnt}, 64'd0);
        chk("t7 rst busy", {63'd0, busy}, 64'd0);
        chk("t7 rst cpl_tready", {63'd0, cpl_tready}, 64'd0);
        areset = 1'b0; EN = 1'b0; TDH = 16'd9;
        tick();
        chk("t7 idle loads TDH", {48'd0, fetch_ptr}, 64'd9);
        chk("t7 idle valid", {63'd0, cmd_tvalid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_desc_fetch.md
# tx_desc_fetch

Transmit descriptor fetch engine for the e1000 transmit path. It tracks the fetch pointer into the host transmit descriptor ring and computes how many descriptors are pending between that pointer and TDT. It issues iDMA read commands that move them into the local descriptor queue, splitting at ring wrap, burst limit and local free space. It sits beside the transmit control dispatcher: that dispatcher supplies queue free-space, and this block reports each completed fetch back to it.

## Interface
Parameters:
- BURST_MAX, 16: maximum descriptors per iDMA command (1..255).

Ports:
- aclk  in  1  clock.
- areset  in  1  reset; synchronous, active-high.
- EN  in  1  transmit enable.
- TDBA  in  64  ring base address (byte); 16-byte aligned.
- TDLEN  in  13  ring length in 128-byte units; ring size N = TDLEN*8 descriptors.
- TDH  in  16  head register; loaded into fetch pointer while idle.
- TDT  in  16  tail register.
- space_avail  in  8  free descriptor slots in local queue.
- cmd_tdata  out  32  iDMA command beat.
- cmd_tvalid  out  1  command beat valid.
- cmd_tlast  out  1  last command beat.
- cmd_tready  in  1  iDMA accepts beat.
- cpl_tdata  in  32  completion status; [1:0] = AXI resp.
- cpl_tvalid  in  1  completion valid.
- cpl_tlast  in  1  completion last (ignored, single beat).
- cpl_tready  out  1  completion accepted.
- fetch_ptr  out  16  current fetch pointer (descriptor index).
- fetch_done  out  1  one-cycle pulse, fetch completed.
- fetch_cnt  out  8  descriptors in completed fetch; valid with fetch_done.
- busy  out  1  command or completion outstanding.
- err  out  1  one-cycle pulse on error completion.

## Operation
- States: IDLE, CALC, CMD0, CMD1, CMD2, WAIT_CPL, UPDATE, HALT.
- IDLE: fetch_ptr <= TDH every cycle. EN=1 -> CALC.
- CALC: config is valid when N != 0 and TDT < N.
  - pending = TDT>=fptr ? TDT-fptr : TDT+N-fptr (17-bit intermediate).
  - count = min(pending, N-fptr, BURST_MAX, space_avail), registered.
  - EN=0 -> IDLE.
  - Otherwise, if config is valid and count>0 -> CMD0; else stay in CALC and re-evaluate every cycle.
- CMD0: beat {4'h1, 12'h000, count*16[15:0]}.
- CMD1: beat addr[31:0].
- CMD2: beat addr[63:32] with cmd_tlast=1.
- addr = TDBA + fptr*16, 64-bit, computed in CALC.
- Each CMD state advances only on cmd_tvalid&&cmd_tready. CMD2 handshake -> WAIT_CPL.
- WAIT_CPL: cpl_tready=1. On cpl handshake:
  - resp==0 -> UPDATE.
  - resp!=0 -> err pulse, HALT.
- UPDATE:
  - fptr <= (fptr+count==N) ? 0 : fptr+count.
  - fetch_done=1, fetch_cnt=count.
  - -> CALC.
- HALT: no commands; fetch_ptr frozen; EN=0 -> IDLE.
- EN deasserted in CMD0..WAIT_CPL: the command and its completion finish normally (no AXI-stream abandonment), then UPDATE, then CALC sees EN=0 -> IDLE.
- TDT and TDH changes are sampled only in CALC and IDLE; values latched for a command are not altered mid-command.
- busy=1 in CMD0..UPDATE.

## Timing
- Reset: state IDLE, fetch_ptr=0, cmd_tvalid=0, cmd_tlast=0, cmd_tdata=0, cpl_tready=0, fetch_done=0, fetch_cnt=0, busy=0, err=0.
- All outputs are registered or decoded from registered state; no combinational path from cmd_tready or cpl_tvalid to outputs except handshake-qualified state advance.
- Latency from EN=1 in IDLE (pending>0) to first cmd_tvalid: 2 cycles.
- Three command beats take 3 cycles minimum with cmd_tready held high. cmd_tdata is stable while cmd_tvalid&&!cmd_tready.
- fetch_done is asserted the cycle after the completion handshake. The next CALC follows, so the next cmd_tvalid is 2 cycles after fetch_done.
- Wrap: a fetch never crosses index N-1; the remainder is issued as a separate command starting at index 0.
- space_avail=0: stays in CALC, no command.
- areset mid-command drops cmd_tvalid the next cycle. The iDMA side is reset by the same areset.

## Test plan
- TDBA=0x1_0000_0000, TDLEN=2 (N=16), TDH=0, TDT=5, space=64, EN=1 -> beats 0x1000_0050, 0x0000_0000, 0x0000_0001 (tlast); OKAY completion -> fetch_done, fetch_cnt=5, fetch_ptr=5.
- N=16, fptr=12, TDT=3 -> command for 4 descriptors at index 12 (len 0x40), fetch_ptr=0. Then command for 3 at index 0, fetch_ptr=3.
- N=64, TDT=40, BURST_MAX=16, space_avail=10 -> fetch_cnt sequence 10; then with space_avail=64: 16, 14; final fetch_ptr=40.
- cmd_tready stalled 5 cycles on CMD1 -> beat held stable, no duplicate beat. cpl resp=2 -> err pulse, fetch_ptr unchanged, no further commands until EN=0 then EN=1 (reloads TDH).
- EN dropped during WAIT_CPL -> completion accepted, fetch_done pulses, then IDLE. TDLEN=0 or TDT>=N -> no cmd_tvalid ever.
- areset asserted in CMD1 -> next cycle all outputs at reset values, state IDLE.
